iir_biquad_sequencer: RTL and testbench

Time-multiplexed controller that runs a cascade of NSEC second-order IIR (biquad) sections on one shared multiply-accumulate unit, one product per cycle.
- Accepts one input sample per transaction and sequences all section computations.
- Keeps per-section delay-line state and a writable coefficient bank.
- Returns the final-section output through a valid/ready handshake.
- Replaces per-section hard-wired shift-add filter stages when several stages must share one multiplier.

---
 rtl/iir_biquad_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_iir_biquad_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_biquad_sequencer.sv
// Cascade of NSEC biquad sections time-sharing one multiplier (one product per cycle),
// with per-section delay lines, a writable coefficient bank and a valid/ready result port.
module iir_biquad_sequencer #(
    parameter int DW    = 12,
    parameter int CW    = 12,
    parameter int ACCW  = 32,
    parameter int NSEC  = 2,
    parameter int SHIFT = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    input  logic          coef_we,
    input  logic [5:0]    coef_addr,
    input  logic [CW-1:0] coef_wdata,
    input  logic          clear_state,
    output logic          coef_err,
    output logic          sat_flag,
    output logic          busy,
    output logic [1:0]    dbg_state
);
    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both
    // high; a raised out_valid holds out_data stable until that edge.
    localparam int NCOEF = 5 * NSEC;
    localparam int SW    = (NSEC > 1) ? $clog2(NSEC) : 1;
    localparam int CAW   = $clog2(NCOEF);
    localparam int PW    = DW + CW;
    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(2 ** (DW - 1) - 1);
    localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_DONE} state_t;

    state_t                 r_state;
    logic [SW-1:0]          r_sec;
    logic [2:0]             r_k;
    logic signed [ACCW-1:0] r_acc;
    logic signed [DW-1:0]   r_x;
    logic signed [DW-1:0]   r_x1 [NSEC];
    logic signed [DW-1:0]   r_x2 [NSEC];
    logic signed [DW-1:0]   r_y1 [NSEC];
    logic signed [DW-1:0]   r_y2 [NSEC];
    logic signed [CW-1:0]   r_coef [NCOEF];
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic signed [DW-1:0]   r_out_data;
    logic                   r_coef_err;
    logic                   r_sat_flag;
    logic                   r_busy;

    logic [CAW-1:0]         w_cidx;
    logic signed [CW-1:0]   w_coef;
    logic signed [DW-1:0]   w_opnd;
    logic signed [PW-1:0]   w_prod;
    logic signed [ACCW-1:0] w_prod_ext;
    logic signed [ACCW-1:0] w_shifted;
    logic                   w_sat_hi;
    logic                   w_sat_lo;
    logic signed [DW-1:0]   w_y;
    logic                   w_addr_ok;

    function automatic logic signed [CW-1:0] default_coef(input int k);
        case (k)
            0, 2:    return CW'(30);
            1:       return CW'(40);
            3:       return CW'(707);
            default: return CW'(212);
        endcase
    endfunction

    assign w_cidx = CAW'(int'(r_sec) * 5 + int'(r_k));
    assign w_coef = r_coef[w_cidx];

    always_comb begin
        w_opnd = r_x;
        case (r_k)
            3'd1:    w_opnd = r_x1[r_sec];
            3'd2:    w_opnd = r_x2[r_sec];
            3'd3:    w_opnd = r_y1[r_sec];
            3'd4:    w_opnd = r_y2[r_sec];
            default: w_opnd = r_x;
        endcase
    end

    assign w_prod     = w_coef * w_opnd;
    assign w_prod_ext = {{(ACCW - PW){w_prod[PW-1]}}, w_prod};
    assign w_shifted  = r_acc >>> SHIFT;
    assign w_sat_hi   = w_shifted > SAT_MAX;
    assign w_sat_lo   = w_shifted < SAT_MIN;
    assign w_y        = w_sat_hi ? {1'b0, {(DW - 1){1'b1}}} :
                        w_sat_lo ? {1'b1, {(DW - 1){1'b0}}} : w_shifted[DW-1:0];
    assign w_addr_ok  = coef_addr < 6'(NCOEF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sec       <= '0;
            r_k         <= '0;
            r_acc       <= '0;
            r_x         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_coef_err  <= 1'b0;
            r_sat_flag  <= 1'b0;
            r_busy      <= 1'b0;
            for (int i = 0; i < NCOEF; i++) r_coef[i] <= default_coef(i % 5);
            for (int s = 0; s < NSEC; s++) begin
                r_x1[s] <= '0;
                r_x2[s] <= '0;
                r_y1[s] <= '0;
                r_y2[s] <= '0;
            end
        end else begin
            r_coef_err <= coef_we && (r_state != S_IDLE || !w_addr_ok);
            case (r_state)
                S_IDLE: begin
                    // The write lands before a coincident sample reaches its first product.
                    if (coef_we && w_addr_ok) r_coef[coef_addr[CAW-1:0]] <= coef_wdata;
                    if (clear_state) begin
                        r_sat_flag <= 1'b0;
                        for (int s = 0; s < NSEC; s++) begin
                            r_x1[s] <= '0;
                            r_x2[s] <= '0;
                            r_y1[s] <= '0;
                            r_y2[s] <= '0;
                        end
                    end else if (in_valid) begin
                        r_x        <= in_data;
                        r_sec      <= '0;
                        r_k        <= '0;
                        r_acc      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (r_k == 3'd4) begin
                        r_acc   <= r_acc - w_prod_ext;
                        r_state <= S_WB;
                    end else begin
                        r_acc <= r_acc + w_prod_ext;
                        r_k   <= r_k + 3'd1;
                    end
                end
                S_WB: begin
                    r_x2[r_sec] <= r_x1[r_sec];
                    r_x1[r_sec] <= r_x;
                    r_y2[r_sec] <= r_y1[r_sec];
                    r_y1[r_sec] <= w_y;
                    if (w_sat_hi || w_sat_lo) r_sat_flag <= 1'b1;
                    if (r_sec != SW'(NSEC - 1)) begin
                        r_x     <= w_y;
                        r_sec   <= r_sec + 1'b1;
                        r_k     <= '0;
                        r_acc   <= '0;
                        r_state <= S_MAC;
                    end else begin
                        r_out_data <= w_y;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    // First DONE cycle registers out_valid; it then holds until accepted.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign coef_err  = r_coef_err;
    assign sat_flag  = r_sat_flag;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_iir_biquad_sequencer.sv
// Bench for iir_biquad_sequencer: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a plain-arithmetic cascade model.
`timescale 1ns/1ps
module tb_iir_biquad_sequencer;
    localparam int DW    = 12;
    localparam int CW    = 12;
    localparam int NSEC  = 2;
    localparam int SHIFT = 11;
    localparam int NCOEF = 5 * NSEC;
    localparam int LAT   = 6 * NSEC + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          coef_we = 1'b0;
    logic [5:0]    coef_addr = '0;
    logic [CW-1:0] coef_wdata = '0;
    logic          clear_state = 1'b0;
    logic          coef_err;
    logic          sat_flag;
    logic          busy;
    logic [1:0]    dbg_state;

    iir_biquad_sequencer #(.DW(DW), .CW(CW), .ACCW(32), .NSEC(NSEC), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .clear_state(clear_state), .coef_err(coef_err), .sat_flag(sat_flag),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- scoreboard and model ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_q[$];
    int m_coef [NCOEF];
    int m_x1 [NSEC];
    int m_x2 [NSEC];
    int m_y1 [NSEC];
    int m_y2 [NSEC];
    bit m_sat, m_busy, exp_err, prev_ov;
    int acc_edge;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int s = 0; s < NSEC; s++) begin
            m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
        end
        m_sat = 1'b0;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < NSEC; s++) begin
            m_coef[s*5+0] = 30;  m_coef[s*5+1] = 40; m_coef[s*5+2] = 30;
            m_coef[s*5+3] = 707; m_coef[s*5+4] = 212;
        end
        model_clear();
    endfunction

    // y[n] = (b0*x + b1*x1 + b2*x2 + a1*y1 - a2*y2) / 2^SHIFT (floor), clamped to DW bits.
    function automatic int model_run(input int xin);
        int x, acc, y;
        x = xin;
        for (int s = 0; s < NSEC; s++) begin
            acc = m_coef[s*5+0] * x + m_coef[s*5+1] * m_x1[s] + m_coef[s*5+2] * m_x2[s]
                + m_coef[s*5+3] * m_y1[s] - m_coef[s*5+4] * m_y2[s];
            y = acc >>> SHIFT;
            if (y > 2047) begin y = 2047; m_sat = 1'b1; end
            else if (y < -2048) begin y = -2048; m_sat = 1'b1; end
            m_x2[s] = m_x1[s]; m_x1[s] = x; m_y2[s] = m_y1[s]; m_y1[s] = y;
            x = y;
        end
        return x;
    endfunction

    always @(negedge clk) begin
        int idx;
        if (rst) begin
            model_reset();
            exp_q.delete();
            m_busy = 1'b0; exp_err = 1'b0; prev_ov = 1'b0;
        end else begin
            chk("busy", int'(busy), int'(m_busy));
            chk("in_ready", int'(in_ready), int'(!m_busy));
            chk("coef_err", int'(coef_err), int'(exp_err));
            if (out_valid) begin
                if (exp_q.size() == 0) chk("spurious_out_valid", 1, 0);
                else begin
                    chk("out_data", int'($signed(out_data)), int'($signed(exp_q[0])));
                    chk("sat_flag", int'(sat_flag), int'(m_sat));
                    if (!prev_ov) chk("latency", edge_cnt - acc_edge, LAT);
                end
            end
            prev_ov = out_valid;
            idx = int'(coef_addr);
            exp_err = coef_we && (m_busy || idx >= NCOEF);
            if (coef_we && !m_busy && idx < NCOEF) m_coef[idx] = int'($signed(coef_wdata));
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                m_busy = 1'b0;
            end else if (!m_busy) begin
                if (clear_state) model_clear();
                else if (in_valid) begin
                    exp_q.push_back(DW'(model_run(int'($signed(in_data)))));
                    m_busy   = 1'b1;
                    acc_edge = edge_cnt + 1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic write_coef(input int addr, input int val);
        coef_we = 1'b1; coef_addr = 6'(addr); coef_wdata = CW'(val);
        step();
        coef_we = 1'b0;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 100) begin step(); t++; end
        if (t >= 100) chk("wait_in_ready_timeout", 0, 1);
    endtask

    task automatic start(input int d);
        wait_ready();
        in_valid = 1'b1; in_data = DW'(d);
        step();
        in_valid = 1'b0; in_data = DW'($urandom_range(0, 4095));
    endtask

    task automatic wait_out(output int got);
        int t = 0;
        got = 0;
        while (!out_valid && t < 40) begin @(negedge clk); t++; end
        if (!out_valid) chk("wait_out_valid_timeout", 0, 1);
        else got = int'($signed(out_data));
    endtask

    task automatic send(input int d, output int got);
        start(d);
        wait_out(got);
        step();
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int got, v;
        repeat (3) step();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_coef_err", int'(coef_err), 0);
        chk("rst_sat_flag", int'(sat_flag), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        step();

        // Section 1 becomes y = -x so the output reflects section 0 directly.
        write_coef(5, -2048);
        for (int k = 6; k < 10; k++) write_coef(k, 0);
        out_ready = 1'b1;
        send(100, got); chk("impulse_0", got, -1);
        send(0, got);   chk("impulse_1", got, -2);
        send(0, got);   chk("impulse_2", got, -2);
        chk("impulse_sat_flag", int'(sat_flag), 0);

        // Backpressure: result held, no new sample accepted, exactly one handshake.
        out_ready = 1'b0;
        start(37);
        wait_out(v);
        step();
        for (int i = 0; i < 20; i++) begin
            in_valid = (i == 7);
            chk("bp_hold_data", int'($signed(out_data)), v);
            chk("bp_in_ready", int'(in_ready), 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_released_valid", int'(out_valid), 0);
        chk("bp_released_ready", int'(in_ready), 1);

        // Saturation, then clear_state wipes sat_flag and history.
        write_coef(0, -2048);
        for (int k = 1; k < 5; k++) write_coef(k, 0);
        send(-2048, got); chk("sat_out", got, -2047);
        chk("sat_flag_set", int'(sat_flag), 1);
        clear_state = 1'b1; in_valid = 1'b1; in_data = DW'(55);
        step();
        clear_state = 1'b0; in_valid = 1'b0;
        chk("clear_blocks_accept", int'(busy), 0);
        chk("clear_sat_flag", int'(sat_flag), 0);
        write_coef(0, 30); write_coef(1, 40); write_coef(2, 30);
        write_coef(3, 707); write_coef(4, 212);
        send(100, got); chk("after_clear", got, -1);

        // Config guard: writes while busy and out-of-range writes are rejected.
        start(300);
        step();
        coef_we = 1'b1; coef_addr = 6'd0; coef_wdata = '0;
        step();
        coef_we = 1'b0;
        chk("busy_write_err", int'(coef_err), 1);
        wait_out(got);
        step();
        send(300, got);
        write_coef(NCOEF, 5);
        chk("range_write_err", int'(coef_err), 1);
        step();
        chk("err_is_pulse", int'(coef_err), 0);

        // Reset mid-run: no result, reset coefficients, impulse reproduces.
        start(100);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        write_coef(5, -2048);
        for (int k = 6; k < 10; k++) write_coef(k, 0);
        send(100, got); chk("midrst_imp_0", got, -1);
        send(0, got);   chk("midrst_imp_1", got, -2);
        send(0, got);   chk("midrst_imp_2", got, -2);

        // Randomized traffic; the compare process checks every cycle.
        for (int c = 0; c < 1500; c++) begin
            in_valid    = ($urandom_range(0, 3) == 0);
            in_data     = DW'($urandom_range(0, 4095));
            out_ready   = ($urandom_range(0, 9) < 7);
            coef_we     = ($urandom_range(0, 9) == 0);
            coef_addr   = 6'($urandom_range(0, 12));
            coef_wdata  = ($urandom_range(0, 1) == 0) ? CW'($urandom_range(0, 4095))
                                                      : CW'(int'($urandom_range(0, 1023)) - 512);
            clear_state = ($urandom_range(0, 39) == 0);
            step();
        end
        in_valid = 1'b0; coef_we = 1'b0; clear_state = 1'b0; out_ready = 1'b1;
        repeat (40) step();
        chk("drain_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
